iir_out_fifo: RTL and testbench

Output buffer placed directly downstream of the IIR filter. Captures every valid 9-bit filtered sample (`din`/`vin` driven by the filter's `dout`/`vout`) into a small circular FIFO. Presents samples to the data sink with a show-ahead valid/ready handshake. Flags lost samples when the sink stalls longer than the buffer can absorb. The filter has no back-pressure input, so this block absorbs all sink stalls.

---
 rtl/iir_pkg.sv | 8 +
 rtl/iir_out_fifo_if.sv | 18 +
 rtl/fifo_regfile.sv | 22 ++
 rtl/iir_out_fifo.sv | 47 ++++
 tb/tb_iir_out_fifo.sv | 125 ++++++++++++
 5 files changed

// File: rtl/iir_pkg.sv
// iir_pkg: shared IIR datapath constants and the FIFO pointer-width helper
package iir_pkg;
    localparam int NB    = 9;
    localparam int DEPTH = 8;
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/iir_out_fifo_if.sv
// iir_out_fifo_if: sample-in / show-ahead-out bundle; slave = FIFO, master = filter+sink side
interface iir_out_fifo_if #(
    parameter int NB    = iir_pkg::NB,
    parameter int DEPTH = iir_pkg::DEPTH
);
    localparam int CW = iir_pkg::ptr_w(DEPTH) + 1;
    logic [NB-1:0] din;
    logic          vin;
    logic          rd_en;
    logic          clr_ovf;
    logic [NB-1:0] dout;
    logic          vout;
    logic          full;
    logic [CW-1:0] count;
    logic          ovf;
    modport slave  (input  din, vin, rd_en, clr_ovf, output dout, vout, full, count, ovf);
    modport master (output din, vin, rd_en, clr_ovf, input  dout, vout, full, count, ovf);
endinterface

// File: rtl/fifo_regfile.sv
// fifo_regfile: DEPTH x NB storage, one sync write port, one async read port, cleared on reset
module fifo_regfile #(
    parameter int NB    = iir_pkg::NB,
    parameter int DEPTH = iir_pkg::DEPTH,
    parameter int PW    = iir_pkg::ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [NB-1:0] wdata,
    input  logic [PW-1:0] raddr,
    output logic [NB-1:0] rdata
);
    logic [NB-1:0] mem [DEPTH];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (we)
            mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/iir_out_fifo.sv
// iir_out_fifo: circular output buffer after the IIR filter; show-ahead read, sticky ovf on dropped samples
module iir_out_fifo #(
    parameter int NB    = iir_pkg::NB,
    parameter int DEPTH = iir_pkg::DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    iir_out_fifo_if.slave bus
);
    localparam int PW = iir_pkg::ptr_w(DEPTH);
    localparam int CW = PW + 1;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          ovf_q, vout, full, pop, push, drop;
    assign vout = cnt != '0;
    assign full = cnt == CW'(DEPTH);
    assign pop  = vout & bus.rd_en;
    // a full FIFO still accepts a sample when the head leaves in the same cycle
    assign push = bus.vin & (~full | pop);
    assign drop = bus.vin & full & ~pop;
    fifo_regfile #(.NB(NB), .DEPTH(DEPTH), .PW(PW)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.din),
        .raddr (rd_ptr),
        .rdata (bus.dout)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            cnt    <= cnt + CW'(push) - CW'(pop);
            // a drop wins over a clear in the same cycle
            ovf_q  <= drop | (ovf_q & ~bus.clr_ovf);
        end
    assign bus.vout  = vout;
    assign bus.full  = full;
    assign bus.count = cnt;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_iir_out_fifo.sv
// tb_iir_out_fifo: directed checks of fill, overflow, push+pop at full, wrap-around and async reset
module tb_iir_out_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    iir_out_fifo_if bus ();
    iir_out_fifo dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [8:0] d, input logic r, input logic c);
        bus.vin = v;
        bus.din = d;
        bus.rd_en = r;
        bus.clr_ovf = c;
        @(posedge clk);
        #1;
    endtask

    int q[$];
    int drain_exp[8] = '{2, 3, 4, 5, 6, 7, 8, 'h1FF};

    initial begin
        bus.vin = 1'b0;
        bus.din = '0;
        bus.rd_en = 1'b0;
        bus.clr_ovf = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_vout", bus.vout, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_dout", bus.dout, 0);
        @(negedge clk) rst_n = 1'b1;

        cyc(1, 9'h0A5, 0, 0);
        chk("single_vout", bus.vout, 1);
        chk("single_dout", bus.dout, 'h0A5);
        chk("single_count", bus.count, 1);
        cyc(0, 0, 1, 0);
        chk("single_pop_vout", bus.vout, 0);
        chk("single_pop_count", bus.count, 0);
        cyc(0, 0, 1, 0);
        chk("empty_rd_count", bus.count, 0);

        for (int i = 1; i <= 8; i++) cyc(1, 9'(i), 0, 0);
        chk("fill_full", bus.full, 1);
        chk("fill_count", bus.count, 8);
        chk("fill_dout", bus.dout, 1);
        chk("fill_ovf", bus.ovf, 0);
        cyc(1, 9'd9, 0, 0);
        chk("drop_ovf", bus.ovf, 1);
        chk("drop_count", bus.count, 8);
        chk("drop_dout", bus.dout, 1);
        cyc(0, 0, 0, 1);
        chk("clr_ovf", bus.ovf, 0);

        cyc(1, 9'h1FF, 1, 0);
        chk("fullpp_count", bus.count, 8);
        chk("fullpp_ovf", bus.ovf, 0);
        chk("fullpp_dout", bus.dout, 2);
        cyc(1, 9'h055, 0, 1);
        chk("drop_clr_ovf", bus.ovf, 1);
        chk("drop_clr_count", bus.count, 8);
        cyc(0, 0, 0, 1);
        chk("clr_later_ovf", bus.ovf, 0);

        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain_dout%0d", k), bus.dout, drain_exp[k]);
            cyc(0, 0, 1, 0);
        end
        chk("drain_vout", bus.vout, 0);
        chk("drain_count", bus.count, 0);

        for (int i = 0; i < 3; i++) begin
            cyc(1, 9'('h0F0 + i), 0, 0);
            q.push_back('h0F0 + i);
        end
        chk("wrap_pre_count", bus.count, 3);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("wrap_dout%0d", i), bus.dout, q.pop_front());
            cyc(1, 9'('h100 + i), 1, 0);
            q.push_back('h100 + i);
            chk($sformatf("wrap_count%0d", i), bus.count, 3);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wrap_tail%0d", i), bus.dout, q.pop_front());
            cyc(0, 0, 1, 0);
        end
        chk("wrap_empty", bus.vout, 0);

        for (int i = 0; i < 5; i++) cyc(1, 9'('h11 + i), 0, 0);
        cyc(0, 0, 0, 0);
        chk("mid_count", bus.count, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vout", bus.vout, 0);
        chk("arst_count", bus.count, 0);
        chk("arst_ovf", bus.ovf, 0);
        chk("arst_dout", bus.dout, 0);
        chk("arst_full", bus.full, 0);
        @(negedge clk) rst_n = 1'b1;
        cyc(1, 9'h003, 0, 0);
        chk("post_rst_dout", bus.dout, 3);
        chk("post_rst_count", bus.count, 1);
        chk("post_rst_vout", bus.vout, 1);
        cyc(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
